// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO special-register controller.
package hilo_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIV_ITERS = WIDTH_DEF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_ctrl_div_core.sv
// Unsigned restoring divider: one shift-subtract step per cycle, WIDTH steps per divide.
module hilo_ctrl_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             finish_o
);

  localparam int CW = $clog2(WIDTH);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic [WIDTH:0]   shifted, diff;

  // finish marks the cycle in which the last iteration is being performed
  assign finish_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    rem_d = shifted[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (finish_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

  // Datapath carries no reset; it is always reloaded by start
  always_ff @(posedge clk) begin
    if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register owner: single-cycle multiply/move, iterative divide with pipeline stall.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, qneg_q, rneg_q;

  op_e              op_in;
  logic             is_div, is_signed, div_zero, accept_div;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic             div_finish;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_in      = op_e'(op);
  assign is_div     = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_signed  = (op_in == OP_DIV) || (op_in == OP_MULT);
  assign div_zero   = (src_b == '0);
  assign accept_div = (state_q == ST_IDLE) && op_valid && !flush && is_div && !div_zero;

  assign abs_a = apply_sign(src_a, is_signed && src_a[WIDTH-1]);
  assign abs_b = apply_sign(src_b, is_signed && src_b[WIDTH-1]);

  // Low 2*WIDTH bits of the product of sign/zero-extended operands give both MULT and MULTU
  assign ext_a = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;

  assign stallreq = ((state_q == ST_IDLE) && op_valid && !flush && is_div)
                  || (state_q == ST_DIV_RUN) || (state_q == ST_DIV_FIX);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  hilo_ctrl_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept_div),
    .abort_i    (flush),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quotient_o (quo),
    .remainder_o(rem),
    .finish_o   (div_finish)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_in)
              OP_MULT, OP_MULTU: begin
                {hi_q, lo_q} <= prod;
                done_q       <= 1'b1;
              end
              OP_MTHI: begin
                hi_q   <= src_a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= src_a;
                done_q <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                  hi_q    <= src_a;
                  lo_q    <= '1;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  qneg_q  <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  rneg_q  <= is_signed && src_a[WIDTH-1];
                  state_q <= ST_DIV_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        ST_DIV_RUN: begin
          if (div_finish) state_q <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          lo_q    <= apply_sign(quo, qneg_q);
          hi_q    <= apply_sign(rem, rneg_q);
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        // The held instruction advances here; op_valid is deliberately ignored
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios plus randomized ops against a reference model.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, done;
  logic [31:0] hi_o, lo_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_hi, exp_lo;

  hilo_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .op_valid(op_valid),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .stallreq(stallreq),
    .done    (done),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Architectural result of one op, computed from the instruction semantics
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] nhi, output logic [31:0] nlo,
                                output int nstall);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    nhi = exp_hi;
    nlo = exp_lo;
    nstall = 0;
    case (o)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        nhi = sp[63:32];
        nlo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        nhi = up[63:32];
        nlo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          nhi = a;
          nlo = 32'hFFFF_FFFF;
          nstall = 1;
        end else begin
          if (o == OP_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q = sa / sb;
          r = sa % sb;
          nlo = q[31:0];
          nhi = r[31:0];
          nstall = 34;
        end
      end
      OP_MTHI: nhi = a;
      OP_MTLO: nlo = a;
      default: ;
    endcase
  endfunction

  // Issue one op from EX, holding it while stalled; flush_at selects the stalled cycle to flush (-1: never)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    logic [31:0] nhi, nlo;
    int nstall, stalls, dones;
    model(o, a, b, nhi, nlo, nstall);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    stalls = 0;
    dones = 0;
    forever begin
      flush = (stalls == flush_at);
      #1;
      if (done) dones++;
      if (flush || !stallreq || stalls >= 200) break;
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 200) begin
      chk("stall_timeout", 64'(stalls), 64'(nstall));
      op_valid = 1'b0;
      flush = 1'b0;
      return;
    end
    if (flush) begin
      @(posedge clk); #1;
      flush = 1'b0;
      op_valid = 1'b0;
      #1;
      chk("flush_stall_low", 64'(stallreq), 64'd0);
      if (done) dones++;
      @(posedge clk); #1;
      if (done) dones++;
      chk("flush_no_done", 64'(dones), 64'd0);
      chk("flush_hi_kept", 64'(hi_o), 64'(exp_hi));
      chk("flush_lo_kept", 64'(lo_o), 64'(exp_lo));
      return;
    end
    chk("stall_cycles", 64'(stalls), 64'(nstall));
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (done) dones++;
    #1;
    chk("no_reissue", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    if (done) dones++;
    chk("done_pulses", 64'(dones), 64'd1);
    exp_hi = nhi;
    exp_lo = nlo;
    chk("hi", 64'(hi_o), 64'(exp_hi));
    chk("lo", 64'(lo_o), 64'(exp_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel, fa;
    rst = 1'b1;
    flush = 1'b0;
    op_valid = 1'b0;
    op = 3'd0;
    src_a = '0;
    src_b = '0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_stall", 64'(stallreq), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, -1);
    chk("mult_const", {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, -1);
    chk("multu_const", {32'(hi_o), 32'(lo_o)}, 64'h0000_0002_FFFF_FFFA);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    chk("div_const", {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd0, -1);
    chk("div0_const", {32'(hi_o), 32'(lo_o)}, 64'h0000_0064_FFFF_FFFF);
    run_op(OP_DIVU, 32'd1000, 32'd7, 11);
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, -1);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, -1);
    chk("mt_const", {32'(hi_o), 32'(lo_o)}, 64'h1234_5678_9ABC_DEF0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("divovf_const", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_8000_0000);
    run_op(OP_MULT, 32'h0000_0005, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel == 2) rb = 32'($urandom_range(1, 15));
      fa = -1;
      if ($urandom_range(0, 7) == 0) begin
        if ((ro == OP_DIV || ro == OP_DIVU) && rb != 32'd0) fa = $urandom_range(0, 33);
        else fa = 0;
      end
      run_op(ro, ra, rb, fa);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
